pid_math: RTL and testbench

//  Parametrised successor of the fixed PD error path: per-sample PID term generator for one flight axis.

---
 rtl/pid_pkg.sv | 34 +++
 rtl/pid_math_sat_signed.sv | 27 ++
 rtl/pid_math.sv | 182 ++++++++++++++++++
 tb/tb_pid_math.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared widths, defaults and width helpers for the PID term generator.
package pid_pkg;

  // Width of the P term: saturated error plus one bit of gain headroom.
  function automatic int pterm_w(input int err_w);
    return err_w + 1;
  endfunction

  // Width of the D term: saturated difference times a 6-bit signed gain.
  function automatic int dterm_w(input int d_sat_w);
    return d_sat_w + 6;
  endfunction

  // Width of the I term: accumulator with the fractional shift removed.
  function automatic int iterm_w(input int acc_w, input int shift);
    return acc_w - shift;
  endfunction

  // Legacy PD path defaults
  localparam int IN_W_DEF    = 16;
  localparam int ERR_W_DEF   = 10;
  localparam int D_DEPTH_DEF = 12;
  localparam int D_SAT_W_DEF = 7;
  localparam int I_ACC_W_DEF = 16;
  localparam int I_SHIFT_DEF = 4;

  localparam logic [3:0] P_NUM_DEF  = 4'd5;
  localparam logic [4:0] D_GAIN_DEF = 5'd7;

  localparam int PTERM_W = pterm_w(ERR_W_DEF);
  localparam int DTERM_W = dterm_w(D_SAT_W_DEF);
  localparam int ITERM_W = iterm_w(I_ACC_W_DEF, I_SHIFT_DEF);

endpackage

// File: rtl/pid_math_sat_signed.sv
// Combinational two's-complement saturator: narrows IN_W bits to OUT_W bits,
// clamping to the most positive / most negative OUT_W value on overflow.
module sat_signed #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 10
) (
  input  logic [IN_W-1:0]  i_din,
  output logic [OUT_W-1:0] o_dout
);

  logic [IN_W-OUT_W:0] w_top;
  logic                w_in_range;

  // Pass the value through when all discarded bits equal the sign, else clamp
  always_comb begin
    w_top      = i_din[IN_W-1:OUT_W-1];
    w_in_range = (&w_top) | ~(|w_top);
    if (w_in_range) begin
      o_dout = i_din[OUT_W-1:0];
    end else if (i_din[IN_W-1]) begin
      o_dout = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      o_dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/pid_math.sv
// Per-sample PID term generator for one flight axis. Stage 0 forms and
// saturates the error, stage 1 registers it, stage 2 produces the P, I and D
// terms. clr wins over any sample in the pipeline.
module pid_math
  import pid_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int ERR_W   = ERR_W_DEF,
  parameter int D_DEPTH = D_DEPTH_DEF,
  parameter int D_SAT_W = D_SAT_W_DEF,
  parameter int I_ACC_W = I_ACC_W_DEF,
  parameter int I_SHIFT = I_SHIFT_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   vld,
  input  logic [IN_W-1:0]                        desired,
  input  logic [IN_W-1:0]                        actual,
  input  logic [3:0]                             p_num,
  input  logic [4:0]                             d_gain,
  input  logic                                   i_en,
  input  logic                                   clr,
  output logic [pterm_w(ERR_W)-1:0]              pterm,
  output logic [iterm_w(I_ACC_W, I_SHIFT)-1:0]   iterm,
  output logic [dterm_w(D_SAT_W)-1:0]            dterm,
  output logic                                   out_vld,
  output logic                                   d_primed
);

  localparam int PT_W   = pterm_w(ERR_W);
  localparam int DT_W   = dterm_w(D_SAT_W);
  localparam int IT_W   = iterm_w(I_ACC_W, I_SHIFT);
  localparam int PP_W   = ERR_W + 5;
  localparam int FILL_W = $clog2(D_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(D_DEPTH);

  // Stage 0 wires
  logic [IN_W:0]      w_err_raw;
  logic [ERR_W-1:0]   w_err_sat;

  // Stage 1 registers
  logic [ERR_W-1:0]   r_err_q;
  logic               r_s1_vld;

  // Stage 2 state
  logic [ERR_W-1:0]   r_win [D_DEPTH];
  logic [FILL_W-1:0]  r_fill;
  logic [FILL_W-1:0]  w_fill_next;
  logic               r_d_primed;
  logic [I_ACC_W-1:0] r_acc;
  logic [PT_W-1:0]    r_pterm;
  logic [IT_W-1:0]    r_iterm;
  logic [DT_W-1:0]    r_dterm;
  logic               r_out_vld;

  // Stage 2 datapath wires
  logic [PP_W-1:0]    w_p_prod;
  logic [ERR_W:0]     w_d_diff;
  logic [D_SAT_W-1:0] w_d_sat;
  logic [DT_W-1:0]    w_d_prod;
  logic [I_ACC_W:0]   w_acc_sum;
  logic [I_ACC_W-1:0] w_acc_next;

  // Error is formed one bit wider than the inputs so it never wraps
  always_comb begin
    w_err_raw = {actual[IN_W-1], actual} - {desired[IN_W-1], desired};
  end

  sat_signed #(.IN_W(IN_W + 1), .OUT_W(ERR_W)) u_sat_err (
    .i_din  (w_err_raw),
    .o_dout (w_err_sat)
  );

  // Stage 2 arithmetic: P product, D difference, integrator sum, fill update
  always_comb begin
    w_p_prod    = {{5{r_err_q[ERR_W-1]}}, r_err_q} * {{(ERR_W+1){1'b0}}, p_num};
    w_d_diff    = r_d_primed
                ? ({r_err_q[ERR_W-1], r_err_q} -
                   {r_win[D_DEPTH-1][ERR_W-1], r_win[D_DEPTH-1]})
                : {(ERR_W+1){1'b0}};
    w_d_prod    = {{6{w_d_sat[D_SAT_W-1]}}, w_d_sat} * {{(D_SAT_W+1){1'b0}}, d_gain};
    w_acc_sum   = {r_acc[I_ACC_W-1], r_acc} +
                  {{(I_ACC_W+1-ERR_W){r_err_q[ERR_W-1]}}, r_err_q};
    w_fill_next = (r_fill == FILL_FULL) ? r_fill : (r_fill + {{(FILL_W-1){1'b0}}, 1'b1});
  end

  sat_signed #(.IN_W(ERR_W + 1), .OUT_W(D_SAT_W)) u_sat_d (
    .i_din  (w_d_diff),
    .o_dout (w_d_sat)
  );

  sat_signed #(.IN_W(I_ACC_W + 1), .OUT_W(I_ACC_W)) u_sat_acc (
    .i_din  (w_acc_sum),
    .o_dout (w_acc_next)
  );

  // Stage 1: capture the saturated error on vld and track pipeline occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_q  <= {ERR_W{1'b0}};
      r_s1_vld <= 1'b0;
    end else if (clr) begin
      r_err_q  <= {ERR_W{1'b0}};
      r_s1_vld <= 1'b0;
    end else begin
      if (vld) begin
        r_err_q <= w_err_sat;
      end
      r_s1_vld <= vld;
    end
  end

  // Output strobe: one pulse per sample leaving stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
    end else if (clr) begin
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= r_s1_vld;
    end
  end

  // P and D terms, using the gains present in this cycle; hold between samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pterm <= {PT_W{1'b0}};
      r_dterm <= {DT_W{1'b0}};
    end else if (clr) begin
      r_pterm <= {PT_W{1'b0}};
      r_dterm <= {DT_W{1'b0}};
    end else if (r_s1_vld) begin
      r_pterm <= w_p_prod[ERR_W+3:3];
      r_dterm <= w_d_prod;
    end
  end

  // Derivative window shift register and its priming counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D_DEPTH; i++) begin
        r_win[i] <= {ERR_W{1'b0}};
      end
      r_fill     <= {FILL_W{1'b0}};
      r_d_primed <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < D_DEPTH; i++) begin
        r_win[i] <= {ERR_W{1'b0}};
      end
      r_fill     <= {FILL_W{1'b0}};
      r_d_primed <= 1'b0;
    end else if (r_s1_vld) begin
      r_win[0] <= r_err_q;
      for (int i = 1; i < D_DEPTH; i++) begin
        r_win[i] <= r_win[i-1];
      end
      r_fill     <= w_fill_next;
      r_d_primed <= (w_fill_next == FILL_FULL);
    end
  end

  // Saturating integrator: pins at the rails instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= {I_ACC_W{1'b0}};
      r_iterm <= {IT_W{1'b0}};
    end else if (clr) begin
      r_acc   <= {I_ACC_W{1'b0}};
      r_iterm <= {IT_W{1'b0}};
    end else if (r_s1_vld && i_en) begin
      r_acc   <= w_acc_next;
      r_iterm <= w_acc_next[I_ACC_W-1:I_SHIFT];
    end
  end

  assign pterm    = r_pterm;
  assign iterm    = r_iterm;
  assign dterm    = r_dterm;
  assign out_vld  = r_out_vld;
  assign d_primed = r_d_primed;

endmodule

// File: tb/tb_pid_math.sv
// Scoreboard bench for pid_math: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever out_vld is seen.
module tb_pid_math;
  import pid_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                vld = 1'b0;
  logic                i_en = 1'b0;
  logic                clr = 1'b0;
  logic [15:0]         desired = 16'd0;
  logic [15:0]         actual = 16'd0;
  logic [3:0]          p_num = P_NUM_DEF;
  logic [4:0]          d_gain = D_GAIN_DEF;
  logic [PTERM_W-1:0]  pterm;
  logic [ITERM_W-1:0]  iterm;
  logic [DTERM_W-1:0]  dterm;
  logic                out_vld;
  logic                d_primed;

  typedef struct {
    int p;
    int i;
    int d;
    int prim;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;

  pid_math dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (vld),
    .desired  (desired),
    .actual   (actual),
    .p_num    (p_num),
    .d_gain   (d_gain),
    .i_en     (i_en),
    .clr      (clr),
    .pterm    (pterm),
    .iterm    (iterm),
    .dterm    (dterm),
    .out_vld  (out_vld),
    .d_primed (d_primed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: compare every presented result against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_vld) begin
      pulses++;
      if (sb_q.size() == 0) begin
        chk("unexpected_out_vld", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("latency_cyc", cyc, e.cyc);
        chk("pterm", int'($signed(pterm)), e.p);
        chk("iterm", int'($signed(iterm)), e.i);
        chk("dterm", int'($signed(dterm)), e.d);
        chk("d_primed", int'(d_primed), e.prim);
      end
    end
  end

  task automatic send(input int des, input int act, input int ep, input int ei,
                      input int ed, input int eprim);
    exp_t e;
    desired = 16'(des);
    actual  = 16'(act);
    vld     = 1'b1;
    e.p = ep; e.i = ei; e.d = ed; e.prim = eprim; e.cyc = cyc + 2;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    vld = 1'b0;
    for (int k = 0; k < 8 && sb_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    chk("drain_queue_empty", sb_q.size(), 0);
  endtask

  task automatic do_clr();
    vld = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int p0;

    // Reset state
    #2;
    chk("rst_pterm", int'(pterm), 0);
    chk("rst_iterm", int'(iterm), 0);
    chk("rst_dterm", int'(dterm), 0);
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_d_primed", int'(d_primed), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: reset mid-stream discards in-flight samples
    send(0, 8, 5, 0, 0, 0);
    send(0, 16, 10, 0, 0, 0);
    vld = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_vld", int'(out_vld), 0);
    chk("midrst_pterm", int'(pterm), 0);
    chk("midrst_d_primed", int'(d_primed), 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 8, 5, 0, 0, 0);
    drain();

    // Test 2: error saturation and P arithmetic (fill stays below depth)
    p_num = 4'd5;
    send(0, 16'sh0300, 319, 0, 0, 0);  idle(3);
    send(0, -1000, -320, 0, 0, 0);     idle(3);
    p_num = 4'd15;
    send(0, -1000, -960, 0, 0, 0);     idle(3);
    p_num = 4'd5;
    send(0, -3, -2, 0, 0, 0);          idle(3);
    p_num = 4'd8;
    send(0, 511, 511, 0, 0, 0);        idle(3);
    p_num = 4'd5;
    drain();

    // Test 3: derivative priming
    do_clr();
    d_gain = 5'd7;
    for (int n = 1; n <= 12; n++) send(0, 100, 62, 0, 0, (n == 12) ? 1 : 0);
    send(0, 120, 75, 0, 140, 1);
    drain();

    // Test 4: derivative difference saturation (positive rail)
    do_clr();
    for (int n = 1; n <= 12; n++) send(0, -512, -320, 0, 0, (n == 12) ? 1 : 0);
    send(0, 511, 319, 0, 441, 1);
    drain();

    // Test 5: anti-windup integrator
    do_clr();
    i_en = 1'b1;
    acc = 0;
    for (int n = 1; n <= 70; n++) begin
      acc = (acc + 500 > 32767) ? 32767 : acc + 500;
      send(0, 500, 312, acc >>> 4, 0, (n >= 12) ? 1 : 0);
    end
    drain();
    chk("windup_pinned_iterm", int'($signed(iterm)), 2047);
    send(0, -500, -313, 2016, -448, 1);
    drain();
    i_en = 1'b0;

    // Test 6: clr beats vld and an in-flight sample
    desired = 16'd0; actual = 16'd50; vld = 1'b1;
    @(posedge clk); #1;
    clr = 1'b1; actual = 16'd77;
    @(posedge clk); #1;
    clr = 1'b0; vld = 1'b0;
    chk("clr_out_vld", int'(out_vld), 0);
    chk("clr_iterm", int'(iterm), 0);
    chk("clr_pterm", int'(pterm), 0);
    chk("clr_dterm", int'(dterm), 0);
    chk("clr_d_primed", int'(d_primed), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("clr_no_out_vld", int'(out_vld), 0);
    end
    @(posedge clk); #1;

    // Back-to-back samples every cycle
    p0 = pulses;
    for (int n = 1; n <= 20; n++) begin
      send(0, 10 * n, (50 * n) >>> 3, 0, (n > 12) ? 441 : 0, (n >= 12) ? 1 : 0);
    end
    drain();
    chk("burst_pulse_count", pulses - p0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
